servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 144 ++++++++++++++
 tb/tb_servo_pwm_multi.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with frame-synchronous updates
//
// Purpose:
//   A shared prescaler produces one tick every DIV clocks. A frame counter
//   runs 0..PERIOD-1 in ticks. Each channel maps its position word linearly
//   onto a pulse width between PW_MIN and PW_MAX ticks. New positions and
//   enables go into pending registers on load. They become active only when
//   the frame counter wraps, so no pulse is ever cut or stretched.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous reset, active low
//   pos_in      - channel i position in bits [i*IN_W +: IN_W]
//   load        - one-cycle strobe capturing pos_in / ch_en into pending registers
//   ch_en       - per-channel enable, captured with load
//   pwm_out     - registered PWM outputs, one per channel
//   frame_start - one-clk pulse in the cycle the frame counter becomes 0 after a wrap
//   tick_out    - one-clk pulse per prescaler tick
module servo_pwm_multi #(
  parameter int N_CH   = 4,
  parameter int IN_W   = 10,
  parameter int DIV    = 50,
  parameter int PERIOD = 20_000,
  parameter int PW_MIN = 500,
  parameter int PW_MAX = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*IN_W-1:0] pos_in,
  input  logic                 load,
  input  logic [N_CH-1:0]      ch_en,
  output logic [N_CH-1:0]      pwm_out,
  output logic                 frame_start,
  output logic                 tick_out
);

  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int RANGE   = PW_MAX - PW_MIN;
  localparam int RANGE_W = (RANGE > 0) ? $clog2(RANGE + 1) : 1;
  // Wide enough for p * RANGE with no overflow; the quotient never exceeds RANGE.
  localparam int PROD_W  = IN_W + RANGE_W;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PERIOD - 1);
  // PW_MAX < PERIOD, so every legal width fits in the counter width.
  localparam logic [CNT_W-1:0]   W_RESET    = CNT_W'(PW_MIN);
  localparam logic [PROD_W-1:0]  SPAN       = PROD_W'(RANGE);
  localparam logic [PROD_W-1:0]  POS_MAX    = PROD_W'((64'd1 << IN_W) - 64'd1);

  if (DIV < 1) begin : g_bad_div
    $error("servo_pwm_multi: DIV must be at least 1");
  end
  if (PW_MIN > PW_MAX) begin : g_bad_pw_order
    $error("servo_pwm_multi: PW_MIN must not exceed PW_MAX");
  end
  if (PW_MAX >= PERIOD) begin : g_bad_pw_max
    $error("servo_pwm_multi: PW_MAX must be below PERIOD");
  end

  function automatic logic [CNT_W-1:0] map_width(input logic [IN_W-1:0] p);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] quot;
    prod = PROD_W'(p) * SPAN;
    quot = prod / POS_MAX;
    return W_RESET + CNT_W'(quot);
  endfunction

  logic [PRESC_W-1:0]          presc_q, presc_d;
  logic                        tick_q, tick_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        frame_start_q, frame_start_d;
  logic [N_CH-1:0][CNT_W-1:0]  pend_w_q, pend_w_d;
  logic [N_CH-1:0][CNT_W-1:0]  act_w_q, act_w_d;
  logic [N_CH-1:0]             pend_en_q, pend_en_d;
  logic [N_CH-1:0]             act_en_q, act_en_d;
  logic [N_CH-1:0]             pwm_q, pwm_d;
  logic                        wrap;

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    // tick_q is high exactly while presc_q holds its last value.
    tick_d  = (presc_d == PRESC_LAST);

    wrap  = tick_q && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (tick_q) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    frame_start_d = wrap;

    pend_w_d  = pend_w_q;
    pend_en_d = pend_en_q;
    if (load) begin
      for (int i = 0; i < N_CH; i++) begin
        pend_w_d[i] = map_width(pos_in[i*IN_W +: IN_W]);
      end
      pend_en_d = ch_en;
    end

    // Taking the _d values lets a load in the wrap cycle apply to the new frame.
    act_w_d  = act_w_q;
    act_en_d = act_en_q;
    if (wrap) begin
      act_w_d  = pend_w_d;
      act_en_d = pend_en_d;
    end

    // The active set changes only while cnt_q = PERIOD-1. Every width is below
    // PERIOD, so the output is already low at that point and no pulse can split.
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = act_en_q[i] && (cnt_q < act_w_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      pend_w_q      <= {N_CH{W_RESET}};
      act_w_q       <= {N_CH{W_RESET}};
      pend_en_q     <= '0;
      act_en_q      <= '0;
      pwm_q         <= '0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      pend_w_q      <= pend_w_d;
      act_w_q       <= act_w_d;
      pend_en_q     <= pend_en_d;
      act_en_q      <= act_en_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign tick_out    = tick_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - directed self-checking bench for servo_pwm_multi
module tb_servo_pwm_multi;

  localparam int N_CH   = 2;
  localparam int IN_W   = 4;
  localparam int DIV    = 2;
  localparam int PERIOD = 20;
  localparam int PW_MIN = 5;
  localparam int PW_MAX = 15;
  localparam int FRAME_CLK = PERIOD * DIV;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH*IN_W-1:0] pos_in;
  logic                 load;
  logic [N_CH-1:0]      ch_en;
  logic [N_CH-1:0]      pwm_out;
  logic                 frame_start;
  logic                 tick_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .N_CH  (N_CH),
    .IN_W  (IN_W),
    .DIV   (DIV),
    .PERIOD(PERIOD),
    .PW_MIN(PW_MIN),
    .PW_MAX(PW_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pos_in     (pos_in),
    .load       (load),
    .ch_en      (ch_en),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .tick_out   (tick_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Entered in the frame_start cycle; leaves in the next frame_start cycle.
  // Optionally drives load for l_n (0..2) cycles starting at offset l_at,
  // first with the a-set of values, then with the b-set.
  task automatic measure_frame(input string tag, input int exp0, input int exp1,
                               input int l_at, input int l_n,
                               input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] aen,
                               input logic [3:0] b0, input logic [3:0] b1, input logic [1:0] ben);
    int hi0 = 0;
    int hi1 = 0;
    int first0 = -1;
    for (int j = 0; j < FRAME_CLK; j++) begin
      if (l_n > 0 && j == l_at) begin
        load = 1'b1; pos_in = {a1, a0}; ch_en = aen;
      end else if (l_n > 1 && j == l_at + 1) begin
        load = 1'b1; pos_in = {b1, b0}; ch_en = ben;
      end else begin
        load = 1'b0;
      end
      if (pwm_out[0]) begin
        hi0++;
        if (first0 < 0) first0 = j;
      end
      if (pwm_out[1]) hi1++;
      step();
    end
    load = 1'b0;
    check_eq({tag, " ch0 clk high"}, hi0, exp0);
    check_eq({tag, " ch1 clk high"}, hi1, exp1);
    check_eq({tag, " frame_start after 40 clk"}, int'(frame_start), 1);
    if (exp0 > 0) check_eq({tag, " ch0 rise offset"}, first0, 1);
  endtask

  initial begin
    int cyc;
    rst    = 1'b0;
    load   = 1'b0;
    pos_in = '0;
    ch_en  = '0;
    repeat (3) step();
    check_eq("reset pwm_out", int'(pwm_out), 0);
    check_eq("reset frame_start", int'(frame_start), 0);
    check_eq("reset tick_out", int'(tick_out), 0);

    // Load before a mid-frame reset; the reset must discard it.
    rst = 1'b1;
    load = 1'b1; pos_in = {4'd0, 4'd15}; ch_en = 2'b11;
    step();
    load = 1'b0;
    repeat (23) step();
    // cycle 24 after release: cnt = 12
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("midreset pwm_out", int'(pwm_out), 0);
    check_eq("midreset frame_start", int'(frame_start), 0);
    check_eq("midreset tick_out c0", int'(tick_out), 0);
    step();
    check_eq("tick_out c1", int'(tick_out), 1);
    step();
    check_eq("tick_out c2", int'(tick_out), 0);
    step();
    check_eq("tick_out c3", int'(tick_out), 1);

    cyc = 3;
    while (!frame_start && cyc < 100) begin
      step();
      cyc++;
    end
    check_eq("first frame_start cycle", cyc, 40);

    // F0: nothing active; load positions 15/0 with both enabled mid-frame.
    measure_frame("F0", 0, 0, 10, 1, 4'd15, 4'd0, 2'b11, 4'd0, 4'd0, 2'b00);
    // F1: ch0 15 ticks, ch1 5 ticks.
    measure_frame("F1", 30, 10, -1, 0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 2'b00);
    // A: load ch0=7 at cnt=3; current frame keeps 15 ticks.
    measure_frame("A", 30, 10, 6, 1, 4'd7, 4'd0, 2'b11, 4'd0, 4'd0, 2'b00);
    // B: ch0 9 ticks; load ch0=0 in the wrap cycle.
    measure_frame("B", 18, 10, 39, 1, 4'd0, 4'd0, 2'b11, 4'd0, 4'd0, 2'b00);
    // C: ch0 5 ticks immediately; load ch_en=01 while ch1 is high.
    measure_frame("C", 10, 10, 4, 1, 4'd0, 4'd15, 2'b01, 4'd0, 4'd0, 2'b00);
    // D: ch1 disabled; two back-to-back loads, only the second should stick.
    measure_frame("D", 10, 0, 2, 2, 4'd15, 4'd0, 2'b11, 4'd8, 4'd3, 2'b11);
    // E: ch0 5+floor(80/15)=10 ticks, ch1 5+floor(30/15)=7 ticks.
    measure_frame("E", 20, 14, -1, 0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
